// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and the uart_tx byte-drain period.
// The drain helper is also used by uart_tx, so both sides agree on bytes-per-clock.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  localparam int CLKS_PER_BIT_DEF = 139;
  localparam int WORDBITS_DEF     = 8;
  localparam int STOPBITS_DEF     = 1;

  // One start bit, the data bits and the stop bits, plus uart_tx's per-byte turnaround.
  function automatic int drain_clks(input int clks_per_bit, input int wordbits, input int stopbits);
    return clks_per_bit * (1 + wordbits + stopbits) + 4;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte streams plus the uart_tx txIn/send write port; slave side is the scheduler.
// Sources see a one-cycle src_ready accept; uart_tx itself has no backpressure.
interface uart_tx_sched_if #(
  parameter int NUM_SRC = 4
) ();

  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic [NUM_SRC-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_send;

  modport master (
    output src_valid, src_data, src_last,
    input  src_ready, grant, tx_data, tx_send
  );

  modport slave (
    input  src_valid, src_data, src_last,
    output src_ready, grant, tx_data, tx_send
  );

endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
// Zero latency; returns all-zero one-hot and index 0 when nothing requests.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx
);

  always_comb begin
    int   c;
    logic found;
    c      = 0;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last) + i) % N;
      if (!found && req[c]) begin
        found     = 1'b1;
        onehot[c] = 1'b1;
        idx       = ($clog2(N))'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet round-robin scheduler in front of uart_tx: grant 1 clk after valid, >=3 clks per byte.
// Writes are paced by a credit model of uart_tx's buffer drain; sources wait while credits are exhausted.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int CREDITS       = 14,
  parameter int DRAIN_CLKS    = drain_clks(CLKS_PER_BIT_DEF, WORDBITS_DEF, STOPBITS_DEF),
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic                           clock,
  input  logic                           reset_n,
  uart_tx_sched_if.slave                 bus,
  output logic                           busy,
  output logic [$clog2(CREDITS+1)-1:0]   credits_used,
  output logic                           trunc_err
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int TW = $clog2(DRAIN_CLKS);
  localparam int BW = $clog2(MAX_PKT_BYTES + 1);

  sched_state_t       state, state_nxt;
  logic [NUM_SRC-1:0] grant_q, pick_oh;
  logic [IW-1:0]      gidx, last_grant, pick_idx;
  logic [BW-1:0]      byte_cnt;
  logic [TW-1:0]      drain_tmr;
  logic [CW-1:0]      credits_q;
  logic [7:0]         tx_data_q;
  logic               tx_send_q, last_q;
  logic               any_req, accept, rel_last, rel_trunc, credit_inc, credit_dec;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req    (bus.src_valid),
    .last   (last_grant),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign any_req = |bus.src_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rel_last  = 1'b0;
    rel_trunc = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nxt = XFER;
      XFER: begin
        if (bus.src_valid[gidx] && (credits_q < CW'(CREDITS))) begin
          accept    = 1'b1;
          state_nxt = PULSE;
        end
      end
      PULSE: state_nxt = GAP;
      GAP: begin
        state_nxt = XFER;
        if (last_q) begin
          rel_last  = 1'b1;
          state_nxt = IDLE;
        end else if (byte_cnt == BW'(MAX_PKT_BYTES)) begin
          rel_trunc = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The grant is one-hot during XFER, so masking it with accept yields the accept pulse.
  assign bus.src_ready = grant_q & {NUM_SRC{accept}};
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_send   = tx_send_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q    <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      byte_cnt   <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      tx_send_q <= accept;
      trunc_err <= rel_trunc;
      if (state == IDLE && any_req) begin
        grant_q    <= pick_oh;
        gidx       <= pick_idx;
        last_grant <= pick_idx;
        byte_cnt   <= '0;
      end
      if (accept) begin
        tx_data_q <= bus.src_data[8*gidx +: 8];
        last_q    <= bus.src_last[gidx];
        byte_cnt  <= byte_cnt + BW'(1);
      end
      if (rel_last || rel_trunc) grant_q <= '0;
    end
  end

  // Credits count bytes believed queued in uart_tx; one drains every DRAIN_CLKS while non-empty.
  assign credit_inc = tx_send_q;
  assign credit_dec = (credits_q != '0) && (drain_tmr == TW'(DRAIN_CLKS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= '0;
      drain_tmr <= '0;
    end else begin
      if (credits_q == '0 || credit_dec) drain_tmr <= '0;
      else                               drain_tmr <= drain_tmr + TW'(1);
      if (credit_inc && !credit_dec && credits_q < CW'(CREDITS))
        credits_q <= credits_q + CW'(1);
      else if (credit_dec && !credit_inc)
        credits_q <= credits_q - CW'(1);
    end
  end

  assign credits_used = credits_q;
  assign busy         = (state != IDLE) || (credits_q != '0);

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Packet-level round-robin scheduler that shares one uart_tx byte interface (txIn / send) between NUM_SRC byte-stream requesters, such as telemetry, debug log and command reply sources.
- uart_tx has no backpressure and a 16-entry write buffer. This block paces writes with a credit counter that models the buffer's drain rate, so the buffer never overflows.
- Sits directly in front of uart_tx: tx_data drives txIn, tx_send drives send.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- CREDITS, 14, maximum bytes outstanding in the uart_tx buffer (less than 16 for margin).
- DRAIN_CLKS, 1394, clocks per byte drained. Default is CLKS_PER_BIT*(1+WORDBITS+STOPBITS)+4 = 139*10+4.
- MAX_PKT_BYTES, 64, forced release of the grant after this many bytes.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  per-source byte valid
- src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i]
- src_last  in  NUM_SRC  byte is last of packet
- src_ready  out  NUM_SRC  one-cycle accept pulse to the granted source
- grant  out  NUM_SRC  one-hot current owner; 0 when idle
- tx_data  out  8  byte to uart_tx txIn
- tx_send  out  1  write strobe to uart_tx send; one cycle high, then at least one cycle low
- busy  out  1  high when state is not IDLE or credits_used is not 0
- credits_used  out  $clog2(CREDITS+1)  bytes believed outstanding
- trunc_err  out  1  one-cycle pulse on a MAX_PKT_BYTES forced release

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, grant=0, src_ready=0, tx_send=0, tx_data=0, credits_used=0, drain timer=0, byte count=0, trunc_err=0, last_grant index=NUM_SRC-1.
- States: IDLE, XFER, PULSE, GAP.
- IDLE:
  - If any src_valid is set, grant the first valid source searching from last_grant+1, wrapping modulo NUM_SRC.
  - Update last_grant, clear the byte count, go to XFER.
  - The grant is registered, one cycle after valid is seen.
- XFER: if src_valid[g] and credits_used<CREDITS:
  - Assert src_ready[g] for one cycle.
  - Latch src_data[g] into tx_data and latch src_last[g].
  - Increment the byte count, go to PULSE.
  - Otherwise hold and wait. The grant is retained while the source is invalid mid-packet; there is no timeout.
- PULSE: tx_send=1 for exactly one cycle; credits_used increments this cycle. Go to GAP.
- GAP: tx_send=0; tx_data stays stable through PULSE and GAP.
  - If the latched last=1: clear grant, go to IDLE.
  - Else if byte count==MAX_PKT_BYTES: pulse trunc_err, clear grant, go to IDLE. The source's remaining bytes form a new packet at its next grant.
  - Else go to XFER.
- Throughput: the minimum is 3 clocks per byte at the block boundary. Sustained rate is credit-limited to 1 byte per DRAIN_CLKS.
- Drain model:
  - The drain timer counts only while credits_used>0.
  - When the timer reaches DRAIN_CLKS-1 it wraps to 0 and credits_used decrements.
  - The timer is cleared whenever credits_used is 0.
  - Increment and decrement in the same cycle leave credits_used unchanged.
  - credits_used never goes below 0 or above CREDITS.
- Fairness: after a packet from source k completes, the search starts at k+1. A source waits at most NUM_SRC-1 packets.
- src_valid on non-granted sources is ignored. src_ready is never asserted to a non-granted source.
- Reset mid-packet: everything returns to reset values immediately and the partial packet is abandoned. The system reset must also reset uart_tx, since the credit model restarts at 0.
- tx_send is never high in two consecutive cycles.

Decomposition:
- Shared package uart_pkg holds:
  - The state encoding constants: IDLE=2'd0, XFER=2'd1, PULSE=2'd2, GAP=2'd3.
  - The default DRAIN_CLKS derivation function from CLKS_PER_BIT, WORDBITS and STOPBITS, shared with uart_tx.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are the request vector and last index; outputs are a one-hot vector and its index. It is reused by future UART/SPI arbiters.

Test Plan:
- Single source 0 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) -> src_ready[0] three pulses 3 clocks apart; tx_send pulses with tx_data 0x11, 0x22, 0x33; credits_used reaches 3; grant returns to 0.
- Sources 1 and 3 hold valid continuously with 1-byte packets -> grant order 1,3,1,3; first grant goes to 1 because last_grant starts at NUM_SRC-1=3.
- Source 2 streams 20 bytes, no last, with MAX_PKT_BYTES=64 -> 14 bytes accepted immediately. Then one byte per 1394 clocks, with no tx_send while credits_used==14.
- Source 0 sends a 65-byte stream, last on byte 65, MAX_PKT_BYTES=64 -> trunc_err pulses after byte 64. Byte 65 is sent under a new grant.
- Drain timing check -> with credits_used=1 and no traffic, it decrements to 0 exactly 1394 clocks after the PULSE cycle.
- reset_n asserted in the middle of a PULSE -> tx_send=0, grant=0 and credits_used=0 asynchronously. After release, the first valid source is granted.
